// File: rtl/uart_arb_pkg.sv
// Shared types and UART register map for the UART port arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAT_ISSUE,
    ST_STAT_WAIT,
    ST_DATA_ISSUE,
    ST_DATA_WAIT,
    ST_GUARD,
    ST_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    RESP_OK      = 2'd0,
    RESP_EMPTY   = 2'd1,
    RESP_TIMEOUT = 2'd2
  } resp_status_e;

  localparam logic [3:0] ADDR_RX_READY = 4'h0;
  localparam logic [3:0] ADDR_RX_DATA  = 4'h1;
  localparam logic [3:0] ADDR_TX_DATA  = 4'h3;
  localparam logic [3:0] ADDR_TX_READY = 4'h4;

endpackage

// File: rtl/uart_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, with wrap.
module rr_arbiter #(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_grant,
  output logic [IdxW-1:0]   grant,
  output logic              any_req
);

  int              idx;
  logic [IdxW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant   = last_grant;
    any_req = |req;
    idx     = 0;
    cand    = '0;
    for (int off = NumReq; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= NumReq) idx = idx - NumReq;
      cand = IdxW'(idx);
      if (req[cand]) grant = cand;
    end
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares the UART CPU register port between NumReq byte requesters,
// running the status-poll plus data-move sequence for each granted request.
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int PollLimit     = 1024,
  parameter int TxGuardCycles = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NumReq-1:0]      req,
  input  logic [NumReq-1:0]      req_we,
  input  logic [NumReq-1:0][7:0] req_wdata,
  output logic [NumReq-1:0]      resp_valid,
  output logic [7:0]             resp_data,
  output logic [1:0]             resp_status,
  output logic                   busy,
  output logic [3:0]             uart_addr,
  output logic [7:0]             uart_wdata,
  output logic                   uart_addr_strobe,
  input  logic [7:0]             uart_data
);

  localparam int IdxW   = $clog2(NumReq);
  localparam int PollW  = (PollLimit < 1) ? 1 : $clog2(PollLimit + 1);
  localparam int GuardW = (TxGuardCycles < 2) ? 1 : $clog2(TxGuardCycles);
  localparam logic [PollW:0]    PollLimitW = (PollW + 1)'(PollLimit);
  localparam logic [GuardW-1:0] GuardLast  =
      (TxGuardCycles < 1) ? '0 : GuardW'(TxGuardCycles - 1);

  arb_state_e        state;
  logic [IdxW-1:0]   grant;
  logic [IdxW-1:0]   last_grant;
  logic [IdxW-1:0]   pick;
  logic              any_req;
  logic              we_q;
  logic [7:0]        wdata_q;
  logic [PollW-1:0]  poll_cnt;
  logic [PollW:0]    poll_inc;
  logic [GuardW-1:0] guard_cnt;
  logic [NumReq-1:0] grant_onehot;

  rr_arbiter #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_rr (
    .req       (req),
    .last_grant(last_grant),
    .grant     (pick),
    .any_req   (any_req)
  );

  // The extra top bit of poll_inc flags a counter that is already saturated.
  assign poll_inc     = {1'b0, poll_cnt} + (PollW + 1)'(1);
  assign grant_onehot = NumReq'(1) << grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      grant            <= '0;
      last_grant       <= IdxW'(NumReq - 1);
      we_q             <= 1'b0;
      wdata_q          <= '0;
      poll_cnt         <= '0;
      guard_cnt        <= '0;
      resp_valid       <= '0;
      resp_data        <= '0;
      resp_status      <= RESP_OK;
      busy             <= 1'b0;
      uart_addr        <= '0;
      uart_wdata       <= '0;
      uart_addr_strobe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant            <= pick;
            we_q             <= req_we[pick];
            wdata_q          <= req_wdata[pick];
            poll_cnt         <= '0;
            uart_addr        <= req_we[pick] ? ADDR_TX_READY : ADDR_RX_READY;
            uart_addr_strobe <= 1'b1;
            busy             <= 1'b1;
            state            <= ST_STAT_ISSUE;
          end
        end

        ST_STAT_ISSUE: begin
          uart_addr_strobe <= 1'b0;
          state            <= ST_STAT_WAIT;
        end

        // Only bit 0 of a status read carries meaning.
        ST_STAT_WAIT: begin
          if (uart_data[0]) begin
            uart_addr_strobe <= 1'b1;
            if (we_q) begin
              uart_addr  <= ADDR_TX_DATA;
              uart_wdata <= wdata_q;
            end else begin
              uart_addr  <= ADDR_RX_DATA;
            end
            state <= ST_DATA_ISSUE;
          end else if (we_q) begin
            poll_cnt <= poll_inc[PollW] ? poll_cnt : poll_inc[PollW-1:0];
            if ((PollLimit != 0) && (poll_inc == PollLimitW)) begin
              resp_valid  <= grant_onehot;
              resp_status <= RESP_TIMEOUT;
              state       <= ST_RESP;
            end else begin
              uart_addr        <= ADDR_TX_READY;
              uart_addr_strobe <= 1'b1;
              state            <= ST_STAT_ISSUE;
            end
          end else begin
            resp_valid  <= grant_onehot;
            resp_status <= RESP_EMPTY;
            state       <= ST_RESP;
          end
        end

        ST_DATA_ISSUE: begin
          uart_addr_strobe <= 1'b0;
          if (!we_q) begin
            state <= ST_DATA_WAIT;
          end else if (TxGuardCycles == 0) begin
            resp_valid  <= grant_onehot;
            resp_status <= RESP_OK;
            state       <= ST_RESP;
          end else begin
            guard_cnt <= '0;
            state     <= ST_GUARD;
          end
        end

        ST_DATA_WAIT: begin
          resp_data   <= uart_data;
          resp_valid  <= grant_onehot;
          resp_status <= RESP_OK;
          state       <= ST_RESP;
        end

        // Give the UART time to drop write_ready before the next TX poll.
        ST_GUARD: begin
          if (guard_cnt == GuardLast) begin
            resp_valid  <= grant_onehot;
            resp_status <= RESP_OK;
            state       <= ST_RESP;
          end else begin
            guard_cnt <= guard_cnt + GuardW'(1);
          end
        end

        ST_RESP: begin
          resp_valid <= '0;
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          resp_valid       <= '0;
          uart_addr_strobe <= 1'b0;
          busy             <= 1'b0;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter with a small registered UART register model.
module tb_uart_port_arbiter;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      req_we = '0;
  logic [1:0][7:0] req_wdata = '0;
  logic [1:0]      resp_valid;
  logic [7:0]      resp_data;
  logic [1:0]      resp_status;
  logic            busy;
  logic [3:0]      uart_addr;
  logic [7:0]      uart_wdata;
  logic            uart_addr_strobe;
  logic [7:0]      uart_data = '0;

  uart_port_arbiter #(
    .NumReq       (2),
    .PollLimit    (4),
    .TxGuardCycles(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_we          (req_we),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_status     (resp_status),
    .busy            (busy),
    .uart_addr       (uart_addr),
    .uart_wdata      (uart_wdata),
    .uart_addr_strobe(uart_addr_strobe),
    .uart_data       (uart_data)
  );

  always #5 clk = ~clk;

  // UART model configuration, written only by the stimulus process
  logic [7:0] rx_stat = '0;
  logic [7:0] rx_byte = '0;
  int         tx_fail = 0;
  bit         tx_stuck = 1'b0;
  int         tx_base = 0;

  // UART model state, written only by the model
  int         strobe_cnt [16];
  logic [7:0] last_tx = '0;
  int         mon_errors = 0;
  logic       prev_strobe = 1'b0;

  initial for (int a = 0; a < 16; a++) strobe_cnt[a] = 0;

  always @(posedge clk) begin
    if (uart_addr_strobe) begin
      strobe_cnt[uart_addr] <= strobe_cnt[uart_addr] + 1;
      case (uart_addr)
        4'h0: uart_data <= rx_stat;
        4'h1: uart_data <= rx_byte;
        4'h3: last_tx <= uart_wdata;
        4'h4: uart_data <= (tx_stuck || ((strobe_cnt[4] - tx_base) < tx_fail)) ? 8'hFE : 8'hFF;
        default: uart_data <= 8'h00;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_strobe && uart_addr_strobe) begin
        mon_errors = mon_errors + 1;
        $display("[TB] FAIL strobe_back_to_back at %0t: actual 1, required 0", $time);
      end
      if ((resp_valid[0] & resp_valid[1]) != 1'b0) begin
        mon_errors = mon_errors + 1;
        $display("[TB] FAIL resp_valid_onehot at %0t: actual %b, required at most one bit", $time, resp_valid);
      end
      prev_strobe = uart_addr_strobe;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  typedef struct {
    logic [1:0] req_mask;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rx_stat;
    logic [7:0] rx_byte;
    int         tx_fail;
    bit         tx_stuck;
    int         exp_lat;
    logic [1:0] exp_status;
    logic [7:0] exp_data;
    int         exp_stat;
    int         exp_dstrb;
  } vec_t;

  localparam int NumVec = 10;
  vec_t vecs [NumVec];
  int   checks = 0;
  int   miscompares = 0;
  int   base_cnt [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rx_stat   = v.rx_stat;
    rx_byte   = v.rx_byte;
    tx_fail   = v.tx_fail;
    tx_stuck  = v.tx_stuck;
    tx_base   = strobe_cnt[4];
    for (int a = 0; a < 16; a++) base_cnt[a] = strobe_cnt[a];
    req_we    = v.we ? v.req_mask : 2'b00;
    req_wdata = {v.wdata, v.wdata};
    req       = v.req_mask;
  endtask

  task automatic waitResp(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic runVector(input int i);
    vec_t v;
    int   lat;
    bit   got;
    int   stat_addr;
    int   data_addr;
    int   total;
    v = vecs[i];
    applyStimulus(v);
    waitResp(lat, got);
    checkOutput($sformatf("v%0d_resp_arrived", i), 32'(got), 32'd1);
    if (got) begin
      stat_addr = v.we ? 4 : 0;
      data_addr = v.we ? 3 : 1;
      total = 0;
      for (int a = 0; a < 16; a++) total += strobe_cnt[a] - base_cnt[a];
      checkOutput($sformatf("v%0d_grant", i), 32'(resp_valid), 32'(v.req_mask));
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      checkOutput($sformatf("v%0d_status", i), 32'(resp_status), 32'(v.exp_status));
      checkOutput($sformatf("v%0d_data", i), 32'(resp_data), 32'(v.exp_data));
      checkOutput($sformatf("v%0d_stat_strobes", i),
                  32'(strobe_cnt[stat_addr] - base_cnt[stat_addr]), 32'(v.exp_stat));
      checkOutput($sformatf("v%0d_data_strobes", i),
                  32'(strobe_cnt[data_addr] - base_cnt[data_addr]), 32'(v.exp_dstrb));
      checkOutput($sformatf("v%0d_total_strobes", i), 32'(total), 32'(v.exp_stat + v.exp_dstrb));
      if (v.we && v.exp_dstrb > 0)
        checkOutput($sformatf("v%0d_tx_byte", i), 32'(last_tx), 32'(v.wdata));
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit got;
    logic [1:0] rr_exp [4];

    //          mask   we    wdata  rxstat rxbyte fail stuck lat status data  stat d
    vecs[0] = '{2'b01, 1'b0, 8'h00, 8'h01, 8'h5A, 0, 1'b0, 5,  2'd0, 8'h5A, 1, 1};
    vecs[1] = '{2'b10, 1'b0, 8'h00, 8'h00, 8'h99, 0, 1'b0, 3,  2'd1, 8'h5A, 1, 0};
    vecs[2] = '{2'b01, 1'b1, 8'hA7, 8'h00, 8'h00, 3, 1'b0, 12, 2'd0, 8'h5A, 4, 1};
    vecs[3] = '{2'b10, 1'b1, 8'h3C, 8'h00, 8'h00, 0, 1'b0, 6,  2'd0, 8'h5A, 1, 1};
    vecs[4] = '{2'b01, 1'b1, 8'h96, 8'h00, 8'h00, 0, 1'b1, 9,  2'd2, 8'h5A, 4, 0};
    vecs[5] = '{2'b10, 1'b1, 8'h11, 8'h00, 8'h00, 0, 1'b0, 6,  2'd0, 8'h5A, 1, 1};
    vecs[6] = '{2'b10, 1'b0, 8'h00, 8'h81, 8'hC3, 0, 1'b0, 5,  2'd0, 8'hC3, 1, 1};
    vecs[7] = '{2'b01, 1'b0, 8'h00, 8'hFE, 8'h77, 0, 1'b0, 3,  2'd1, 8'hC3, 1, 0};
    vecs[8] = '{2'b01, 1'b1, 8'h5E, 8'h00, 8'h00, 1, 1'b0, 8,  2'd0, 8'hC3, 2, 1};
    vecs[9] = '{2'b01, 1'b0, 8'h00, 8'h01, 8'h00, 0, 1'b0, 5,  2'd0, 8'h00, 1, 1};

    rr_exp[0] = 2'b01;
    rr_exp[1] = 2'b10;
    rr_exp[2] = 2'b01;
    rr_exp[3] = 2'b10;

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_strobe", 32'(uart_addr_strobe), 32'd0);
    checkOutput("rst_addr", 32'(uart_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < NumVec; i++) runVector(i);

    $display("[TB] reset mid-operation");
    tx_stuck  = 1'b1;
    req_we    = 2'b01;
    req_wdata = {8'h00, 8'h77};
    req       = 2'b01;
    repeat (2) @(negedge clk);
    checkOutput("mid_busy_before_reset", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_strobe", 32'(uart_addr_strobe), 32'd0);
    checkOutput("mid_rst_addr", 32'(uart_addr), 32'd0);
    checkOutput("mid_rst_wdata", 32'(uart_wdata), 32'd0);
    checkOutput("mid_rst_resp_data", 32'(resp_data), 32'd0);
    checkOutput("mid_rst_resp_status", 32'(resp_status), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    req = 2'b00;
    tx_stuck = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] round-robin after reset");
    rx_stat = 8'h00;
    req_we  = 2'b00;
    req     = 2'b11;
    for (int r = 0; r < 4; r++) begin
      waitResp(lat, got);
      checkOutput($sformatf("rr%0d_resp_arrived", r), 32'(got), 32'd1);
      if (got) begin
        checkOutput($sformatf("rr%0d_grant", r), 32'(resp_valid), 32'(rr_exp[r]));
        checkOutput($sformatf("rr%0d_latency", r), 32'(lat), (r == 0) ? 32'd3 : 32'd4);
        checkOutput($sformatf("rr%0d_status", r), 32'(resp_status), 32'd1);
      end
      if (r == 3) req = 2'b00;
    end
    repeat (2) @(negedge clk);
    checkOutput("final_idle_busy", 32'(busy), 32'd0);
    checkOutput("monitor_errors", 32'(mon_errors), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
